// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared FSM encoding and default widths for seq_divider
package divider_pkg;

  localparam int DEF_DIVIDEND_W = 8;
  localparam int DEF_DIVISOR_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/hex_to_seg.sv
// rtl/hex_to_seg.sv - 4-bit nibble to active-low 7-segment pattern (gfedcba), digits 0-F
module hex_to_seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring sequential divider, one quotient bit per clock
// Optional HEX_DISPLAY_EN adds HEX0..HEX3 seven-segment outputs.
module seq_divider
  import divider_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  dbz
`ifdef HEX_DISPLAY_EN
  ,
  output logic [6:0]            HEX0,
  output logic [6:0]            HEX1,
  output logic [6:0]            HEX2,
  output logic [6:0]            HEX3
`endif
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
  logic [DIVISOR_W:0]    rem_q, rem_d;
  logic [DIVIDEND_W-1:0] quot_q, quot_d;
  logic [DIVISOR_W-1:0]  remo_q, remo_d;
  logic                  dbz_q, dbz_d;

  logic [DIVISOR_W:0]    shift_rem;
  logic [DIVISOR_W:0]    trial;
  logic                  fits;
  logic [DIVISOR_W:0]    rem_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  // dvd_q doubles as the quotient accumulator: dividend bits leave at the MSB,
  // quotient bits enter at the LSB.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    remo_d    = remo_q;
    dbz_d     = dbz_q;
    shift_rem = {rem_q[DIVISOR_W-1:0], dvd_q[DIVIDEND_W-1]};
    trial     = shift_rem - {1'b0, dsr_q};
    fits      = (shift_rem >= {1'b0, dsr_q});
    rem_next  = fits ? trial : shift_rem;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            dvd_d   = dividend;
            dsr_d   = divisor;
            rem_d   = '0;
            cnt_d   = CNT_W'(DIVIDEND_W);
            state_d = S_RUN;
          end else begin
            quot_d  = '1;
            remo_d  = '0;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        rem_d = rem_next;
        dvd_d = {dvd_q[DIVIDEND_W-2:0], fits};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          quot_d  = {dvd_q[DIVIDEND_W-2:0], fits};
          remo_d  = rem_next[DIVISOR_W-1:0];
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign quotient  = quot_q;
  assign remainder = remo_q;
  assign dbz       = dbz_q;

`ifdef HEX_DISPLAY_EN
  logic [7:0] quot_byte;
  logic [3:0] rem_nib;

  assign quot_byte = 8'(quot_q);
  assign rem_nib   = 4'(remo_q);

  hex_to_seg u_hex0 (.nibble(quot_byte[3:0]), .seg(HEX0));
  hex_to_seg u_hex1 (.nibble(quot_byte[7:4]), .seg(HEX1));
  hex_to_seg u_hex2 (.nibble(rem_nib),        .seg(HEX2));

  assign HEX3 = dbz_q ? 7'b0111111 : 7'b1111111;
`endif

endmodule
